quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 111 +++++++++++
 tb/tb_quad_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// ============================================================================
// Module      : quad_decoder
// Description : x4 quadrature decoder with 8-bit position counter, loadable
//               count, wrap pulse, sticky illegal-transition flag and
//               post-reset decode blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_decoder #(
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quad_a,
  input  logic       quad_b,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       clear_err,
  output logic [7:0] out,
  output logic       dir,
  output logic       step,
  output logic       wrap,
  output logic       err
);

  localparam int              c_BW         = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [c_BW-1:0] c_BLANK_INIT = c_BW'(BLANK_CYCLES);

  logic [1:0]      r_sync_a;
  logic [1:0]      r_sync_b;
  logic [1:0]      r_prev;
  logic [c_BW-1:0] r_blank;
  logic [7:0]      r_out;
  logic            r_dir;
  logic            r_step;
  logic            r_wrap;
  logic            r_err;

  logic [1:0]      w_cur;
  logic            w_up;
  logic            w_dn;
  logic            w_illegal;
  logic            w_active;

  // Synchronizers and prev are never reset so they track the pins through
  // reset and blanking; release therefore sees prev == current state.
  always_ff @(posedge clk) begin
    r_sync_a <= {r_sync_a[0], quad_a};
    r_sync_b <= {r_sync_b[0], quad_b};
    r_prev   <= w_cur;
  end

  assign w_cur     = {r_sync_a[1], r_sync_b[1]};
  assign w_illegal = ((r_prev ^ w_cur) == 2'b11);
  assign w_active  = (r_blank == '0);

  always_comb begin
    w_up = 1'b0;
    w_dn = 1'b0;
    case ({r_prev, w_cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: w_up = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: w_dn = 1'b1;
      default: begin
        w_up = 1'b0;
        w_dn = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= 8'h00;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
      r_blank <= c_BLANK_INIT;
    end else begin
      if (!w_active) begin
        r_blank <= r_blank - 1'b1;
      end
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      // Set dominates clear when both happen in the same cycle.
      r_err  <= (r_err & ~clear_err) | (w_active & w_illegal);
      if (load) begin
        r_out <= data;
      end else if (w_active && w_up) begin
        r_out  <= r_out + 8'd1;
        r_dir  <= 1'b1;
        r_step <= 1'b1;
        r_wrap <= (r_out == 8'hFF);
      end else if (w_active && w_dn) begin
        r_out  <= r_out - 8'd1;
        r_dir  <= 1'b0;
        r_step <= 1'b1;
        r_wrap <= (r_out == 8'h00);
      end
    end
  end

  assign out  = r_out;
  assign dir  = r_dir;
  assign step = r_step;
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
// ============================================================================
// Module      : tb_quad_decoder
// Description : Scoreboard bench for quad_decoder; directed quadrature vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       quad_a;
  logic       quad_b;
  logic       load;
  logic [7:0] data;
  logic       clear_err;
  logic [7:0] out;
  logic       dir;
  logic       step;
  logic       wrap;
  logic       err;

  typedef struct {
    logic [7:0] out;
    logic       dir;
    logic       wrap;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  quad_decoder #(.BLANK_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .quad_a    (quad_a),
    .quad_b    (quad_b),
    .load      (load),
    .data      (data),
    .clear_err (clear_err),
    .out       (out),
    .dir       (dir),
    .step      (step),
    .wrap      (wrap),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs applied just after negedge n are decoded at posedge n+3.
  task automatic move(input logic [1:0] ab, input bit exp_step,
                      input logic [7:0] eo, input logic ed, input logic ew);
    quad_a = ab[1];
    quad_b = ab[0];
    if (exp_step) sb.push_back('{out: eo, dir: ed, wrap: ew, cyc: cyc + 3});
    repeat (4) @(negedge clk);
  endtask

  // Monitor: every step pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (wrap === 1'b1 && step !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL wrap_without_step: got wrap=1 step=%b expected step=1 (cycle %0d)", step, cyc);
    end
    if (step === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_step: got step with out=%0h expected no step (cycle %0d)", out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("step_out",  32'(out),  32'(e.out));
        chk("step_dir",  32'(dir),  32'(e.dir));
        chk("step_wrap", 32'(wrap), 32'(e.wrap));
        chk("step_cyc",  32'(cyc),  32'(e.cyc));
      end
    end
  end

  initial begin
    reset = 1'b1; quad_a = 1'b0; quad_b = 1'b0;
    load = 1'b0; data = 8'h00; clear_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out",  32'(out),  32'h00);
    chk("rst_dir",  32'(dir),  32'h0);
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_err",  32'(err),  32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Up sequence through one full electrical cycle
    move(2'b01, 1, 8'h01, 1'b1, 1'b0);
    move(2'b11, 1, 8'h02, 1'b1, 1'b0);
    move(2'b10, 1, 8'h03, 1'b1, 1'b0);
    move(2'b00, 1, 8'h04, 1'b1, 1'b0);
    chk("t1_four_steps", 32'(sb.size()), 32'd0);
    chk("t1_out", 32'(out), 32'h04);
    chk("t1_dir", 32'(dir), 32'h1);
    chk("t1_err", 32'(err), 32'h0);

    // Wrap in both directions
    load = 1'b1; data = 8'hFF;
    @(negedge clk);
    load = 1'b0;
    chk("t2_load", 32'(out), 32'hFF);
    move(2'b01, 1, 8'h00, 1'b1, 1'b1);
    move(2'b00, 1, 8'hFF, 1'b0, 1'b1);
    chk("t2_dir", 32'(dir), 32'h0);

    // Illegal transition, clear, then clear concurrent with illegal
    move(2'b11, 0, 8'h00, 1'b0, 1'b0);
    chk("t3_err_set", 32'(err), 32'h1);
    chk("t3_out",     32'(out), 32'hFF);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("t3_err_clr", 32'(err), 32'h0);
    quad_a = 1'b0; quad_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_err_pre", 32'(err), 32'h0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("t3_set_wins", 32'(err), 32'h1);
    repeat (2) @(negedge clk);
    chk("t3_out2", 32'(out), 32'hFF);

    // Inputs held at 11 through reset and release
    reset = 1'b1; quad_a = 1'b1; quad_b = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_out", 32'(out), 32'h00);
    chk("t4_err", 32'(err), 32'h0);
    chk("t4_dir", 32'(dir), 32'h0);
    move(2'b10, 1, 8'h01, 1'b1, 1'b0);

    // Load on the same cycle an up step would count
    quad_a = 1'b0; quad_b = 1'b0;
    repeat (2) @(negedge clk);
    load = 1'b1; data = 8'h40;
    @(negedge clk);
    load = 1'b0;
    chk("t5_out",  32'(out),  32'h40);
    chk("t5_step", 32'(step), 32'h0);
    chk("t5_wrap", 32'(wrap), 32'h0);
    repeat (3) @(negedge clk);
    chk("t5_hold", 32'(out), 32'h40);

    // Count to 0x23, set err, then reset with a step inside blanking
    load = 1'b1; data = 8'h20;
    @(negedge clk);
    load = 1'b0;
    move(2'b01, 1, 8'h21, 1'b1, 1'b0);
    move(2'b11, 1, 8'h22, 1'b1, 1'b0);
    move(2'b10, 1, 8'h23, 1'b1, 1'b0);
    chk("t6_out", 32'(out), 32'h23);
    move(2'b01, 0, 8'h00, 1'b0, 1'b0);
    chk("t6_err", 32'(err), 32'h1);
    reset = 1'b1; quad_a = 1'b0; quad_b = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_out", 32'(out), 32'h00);
    chk("t6_rst_dir", 32'(dir), 32'h0);
    chk("t6_rst_err", 32'(err), 32'h0);
    repeat (5) @(negedge clk);
    chk("t6_blank_out", 32'(out), 32'h00);
    chk("t6_blank_err", 32'(err), 32'h0);
    move(2'b01, 1, 8'h01, 1'b1, 1'b0);
    chk("t6_resume", 32'(out), 32'h01);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
